ctrl_seq: RTL and testbench
===========================

CTRL_SEQ -- requirements
Module: ctrl_seq

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; clock and reset ports are listed first below.
REQ-002 SHALL provide these ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin execution at pc 0
- stop  in  1  level; finish the current instruction, then go idle
- step  in  1  pulse; advance one instruction (single-step builds only)
- instr  in  32  RAM read data, valid the cycle after mem_rd
- pc_addr  out  9  RAM address
- mem_rd  out  1  RAM read enable
- alufun  out  4  ALU function select
- valC  out  16  latched immediate field
- dstE  out  4  ALU-result write register; 4'hF = no write
- dstM  out  4  load write register; 4'hF = no write
- valM  out  32  load write data
- busy  out  1  high in any state except IDLE, HALT and ERR
- done  out  1  HALT reached
- err  out  1  illegal opcode seen
- icount  out  16  count of retired instructions

Function
REQ-003 SHALL implement the FSM states IDLE, FETCH, WAIT, DECODE, EXEC, WB, PAUSE, HALT and ERR.
REQ-004 IDLE -> FETCH on start=1; pc is cleared to 0, icount is cleared to 0, and done and err are cleared.
REQ-005 FETCH SHALL drive pc_addr=pc with mem_rd=1 for exactly one cycle, then go to WAIT.
REQ-006 WAIT SHALL capture instr into the internal instruction register at the end of the cycle, then go to DECODE.
REQ-007 DECODE SHALL latch valC=ir[15:0] and check opcode ir[31:24]:
- 0x00: HALT
- 0x10: load immediate
- 0x20-0x23: ALU operation
- any other value: go to ERR
REQ-008 EXEC SHALL drive alufun=ir[27:24] for ALU operations and hold alufun unchanged otherwise; lasts exactly one cycle.
REQ-009 WB for an ALU operation SHALL drive dstE=ir[23:20] for exactly one cycle.
REQ-010 WB for a load immediate SHALL drive dstM=ir[19:16] and valM=zero-extended ir[15:0] for exactly one cycle.
REQ-011 In WB, pc SHALL increment (511 wraps to 0) and icount SHALL increment, saturating at 16'hFFFF.
REQ-012 Outside WB, dstE and dstM SHALL be 4'hF.
REQ-013 Each non-halt instruction SHALL take exactly 5 cycles (FETCH to WB) when single-step is off.
REQ-014 After WB: if stop=1 go to IDLE; else go to FETCH. In single-step builds, go to PAUSE instead (REQ-023).
REQ-015 HALT: done=1; the FSM stays until start=1, which restarts as in REQ-004. HALT does not increment icount.
REQ-016 ERR: err=1; pc holds the address of the offending instruction; the FSM stays until start=1.
REQ-017 start SHALL be ignored while busy=1; start and stop asserted together in IDLE SHALL give no start.
REQ-018 stop SHALL be sampled only in WB; stop asserted earlier in an instruction SHALL still let that instruction complete, including its write.
REQ-019 mem_rd SHALL be 0 in every state except FETCH; pc_addr SHALL always equal pc.

Reset
REQ-020 While reset_n=0, at any time including mid-instruction:
- state = IDLE
- pc = 0, icount = 0, valC = 0, valM = 0, alufun = 0
- dstE = dstM = 4'hF
- mem_rd = busy = done = err = 0
REQ-021 A partially executed instruction SHALL produce no register write after reset.
REQ-022 Reset release SHALL take effect synchronously to the next rising edge of clock.

Configuration
REQ-023 With SEQ_STEP_EN defined: WB -> PAUSE; PAUSE -> FETCH on step=1, or -> IDLE on stop=1 (stop has priority); busy=1 in PAUSE.
REQ-024 Without SEQ_STEP_EN: the PAUSE state does not exist, the step port is present but ignored, and timing follows REQ-013.

Verification
REQ-025 Load: program 0x10F00080 at addr 0, 0x00000000 at addr 1; pulse start -> dstM=0, valM=32'h80 in cycle 5; done=1 and icount=1 after the HALT decode.
REQ-026 ALU sequence: 0x20010000, 0x21230000, 0x22450000, 0x23670000, then halt -> dstE=0,2,4,6 with alufun=0,1,2,3, WB cycles 5 clocks apart, icount=4.
REQ-027 Illegal opcode: 0x30000000 at addr 3 -> err=1, pc_addr=3, busy=0, no dstE/dstM write; a later start clears err.
REQ-028 Control: stop raised in the EXEC cycle of instruction 0 -> instruction 0 writes, then IDLE with pc=1; start pulsed mid-run -> no effect on pc.
REQ-029 Reset mid-run: reset_n=0 in the EXEC cycle of an ALU operation -> all outputs at reset values within the same cycle, no write.
REQ-030 Wrap and step: pc=511 instruction retires -> pc=0. With SEQ_STEP_EN, the FSM holds in PAUSE until a step pulse, and each pulse retires exactly one instruction.

Source files
------------

// File: rtl/ctrl_seq.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/write-back over a 512-word RAM.
// Optional single-step mode (PAUSE after every write-back) is enabled by defining SEQ_STEP_EN.
module ctrl_seq (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic        step,
    input  logic [31:0] instr,
    output logic [8:0]  pc_addr,
    output logic        mem_rd,
    output logic [3:0]  alufun,
    output logic [15:0] valC,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [31:0] valM,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] icount
);

    typedef enum logic [3:0] {
        StIdle,
        StFetch,
        StWait,
        StDecode,
        StExec,
        StWb,
        StHalt,
        StErr
`ifdef SEQ_STEP_EN
        , StPause
`endif
    } state_e;

    state_e      state_q, state_d;
    logic [8:0]  pc_q;
    logic [15:0] icount_q;
    logic [31:0] ir_q;
    logic [15:0] valc_q;
    logic [3:0]  alufun_q;

    logic is_halt, is_ld, is_alu, launch;

    assign is_halt = (ir_q[31:24] == 8'h00);
    assign is_ld   = (ir_q[31:24] == 8'h10);
    assign is_alu  = (ir_q[31:26] == 6'b001000);

`ifndef SEQ_STEP_EN
    logic unused_step;
    assign unused_step = step;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (start && !stop) state_d = StFetch;
            StFetch:  state_d = StWait;
            StWait:   state_d = StDecode;
            StDecode: begin
                if (is_halt)              state_d = StHalt;
                else if (is_ld || is_alu) state_d = StExec;
                else                      state_d = StErr;
            end
            StExec:   state_d = StWb;
`ifdef SEQ_STEP_EN
            StWb:     state_d = StPause;
            StPause: begin
                if (stop)      state_d = StIdle;
                else if (step) state_d = StFetch;
            end
`else
            StWb:     state_d = stop ? StIdle : StFetch;
`endif
            StHalt, StErr: if (start) state_d = StFetch;
            default:  state_d = StIdle;
        endcase
    end

    // A new run begins whenever a quiescent state hands over to FETCH.
    assign launch = (state_d == StFetch) &&
                    ((state_q == StIdle) || (state_q == StHalt) || (state_q == StErr));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            icount_q <= '0;
            ir_q     <= '0;
            valc_q   <= '0;
            alufun_q <= '0;
        end else begin
            state_q <= state_d;
            if (launch) begin
                pc_q     <= '0;
                icount_q <= '0;
            end
            if (state_q == StWait)            ir_q     <= instr;
            if (state_q == StDecode)          valc_q   <= ir_q[15:0];
            if (state_q == StExec && is_alu)  alufun_q <= ir_q[27:24];
            if (state_q == StWb) begin
                pc_q <= pc_q + 9'd1;
                if (icount_q != 16'hFFFF) icount_q <= icount_q + 16'd1;
            end
        end
    end

    always_comb begin
        dstE = 4'hF;
        dstM = 4'hF;
        valM = '0;
        if (state_q == StWb) begin
            if (is_alu) dstE = ir_q[23:20];
            if (is_ld) begin
                dstM = ir_q[19:16];
                valM = {16'h0000, ir_q[15:0]};
            end
        end
    end

    assign pc_addr = pc_q;
    assign mem_rd  = (state_q == StFetch);
    assign alufun  = alufun_q;
    assign valC    = valc_q;
    assign icount  = icount_q;
    assign done    = (state_q == StHalt);
    assign err     = (state_q == StErr);
    assign busy    = (state_q != StIdle) && (state_q != StHalt) && (state_q != StErr);

endmodule

// File: tb/tb_ctrl_seq.sv
// Randomized bench for ctrl_seq: an instruction-level model expands each program into the
// expected per-cycle output trace, which is compared against the DUT cycle by cycle.
module tb_ctrl_seq;

    logic        clock = 1'b0;
    logic        reset_n, start, stop, step;
    logic [31:0] instr;
    logic [8:0]  pc_addr;
    logic        mem_rd, busy, done, err;
    logic [3:0]  alufun, dstE, dstM;
    logic [15:0] valC, icount;
    logic [31:0] valM;

    always #5 clock = ~clock;

    ctrl_seq dut (
        .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .step(step),
        .instr(instr), .pc_addr(pc_addr), .mem_rd(mem_rd), .alufun(alufun), .valC(valC),
        .dstE(dstE), .dstM(dstM), .valM(valM), .busy(busy), .done(done), .err(err),
        .icount(icount)
    );

    // RAM: data valid only in the cycle after a read; garbage otherwise.
    logic [31:0] mem [512];
    always @(posedge clock) instr <= mem_rd ? mem[pc_addr] : $urandom;

    // step is ignored in the default build, so keep it noisy.
    always @(negedge clock) step = 1'($urandom);

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          rd, bsy, dn, er, wb, term;
        logic [8:0]  pc;
        logic [3:0]  de, dm, af;
        logic [31:0] vm;
        logic [15:0] vc, icnt;
    } exp_t;

    exp_t       trace[$];
    logic [3:0] m_alufun;

    function automatic exp_t plain(input logic [8:0] pc, input bit rd);
        exp_t e;
        e = '{rd: rd, bsy: 1'b1, dn: 1'b0, er: 1'b0, wb: 1'b0, term: 1'b0, pc: pc,
              de: 4'hF, dm: 4'hF, af: 4'h0, vm: 32'h0, vc: 16'h0, icnt: 16'h0};
        return e;
    endfunction

    // Executes the program in mem from address 0 at instruction level.
    task automatic build_trace();
        logic [8:0]  addr = 0;
        int          retired = 0;
        logic [31:0] w;
        logic [7:0]  op;
        exp_t        e;
        trace.delete();
        for (int n = 0; n < 600; n++) begin
            w  = mem[addr];
            op = w[31:24];
            trace.push_back(plain(addr, 1'b1));
            trace.push_back(plain(addr, 1'b0));
            trace.push_back(plain(addr, 1'b0));
            if (op == 8'h10 || (op >= 8'h20 && op <= 8'h23)) begin
                trace.push_back(plain(addr, 1'b0));
                e = plain(addr, 1'b0);
                e.wb = 1'b1;
                e.vc = w[15:0];
                if (op == 8'h10) begin
                    e.dm = w[19:16];
                    e.vm = {16'h0, w[15:0]};
                end else begin
                    e.de = w[23:20];
                    m_alufun = w[27:24];
                end
                e.af = m_alufun;
                trace.push_back(e);
                retired++;
                addr = addr + 9'd1;
            end else begin
                e = plain(addr, 1'b0);
                e.bsy  = 1'b0;
                e.dn   = (op == 8'h00);
                e.er   = (op != 8'h00);
                e.term = 1'b1;
                e.vc   = w[15:0];
                e.icnt = 16'(retired);
                trace.push_back(e);
                break;
            end
        end
    endtask

    task automatic compare(input exp_t e);
        check("mem_rd", 32'(mem_rd), 32'(e.rd));
        check("busy", 32'(busy), 32'(e.bsy));
        check("done", 32'(done), 32'(e.dn));
        check("err", 32'(err), 32'(e.er));
        check("pc_addr", 32'(pc_addr), 32'(e.pc));
        check("dstE", 32'(dstE), 32'(e.de));
        check("dstM", 32'(dstM), 32'(e.dm));
        check("valM", valM, e.vm);
        if (e.wb) begin
            check("alufun", 32'(alufun), 32'(e.af));
            check("valC_wb", 32'(valC), 32'(e.vc));
        end
        if (e.term) begin
            check("icount", 32'(icount), 32'(e.icnt));
            check("valC_term", 32'(valC), 32'(e.vc));
        end
    endtask

    // Pulses start, then compares every cycle; poke >= 0 re-pulses start mid-run.
    task automatic run_trace(input int poke);
        build_trace();
        @(negedge clock);
        start = 1'b1;
        stop  = 1'b0;
        for (int i = 0; i < trace.size(); i++) begin
            @(negedge clock);
            start = (i == poke);
            compare(trace[i]);
        end
        start = 1'b0;
        repeat (2) begin
            @(negedge clock);
            compare(trace[trace.size() - 1]);
        end
    endtask

    function automatic logic [31:0] rand_legal();
        if ($urandom_range(0, 1) == 0)
            return {8'h10, 4'($urandom), 4'($urandom), 16'($urandom)};
        return {6'b001000, 2'($urandom), 24'($urandom)};
    endfunction

    function automatic logic [31:0] rand_illegal();
        logic [7:0] op;
        do op = 8'($urandom);
        while (op == 8'h00 || op == 8'h10 || op[7:2] == 6'b001000);
        return {op, 24'($urandom)};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_pc"}, 32'(pc_addr), 32'h0);
        check({tag, "_icount"}, 32'(icount), 32'h0);
        check({tag, "_valC"}, 32'(valC), 32'h0);
        check({tag, "_valM"}, valM, 32'h0);
        check({tag, "_alufun"}, 32'(alufun), 32'h0);
        check({tag, "_dstE"}, 32'(dstE), 32'hF);
        check({tag, "_dstM"}, 32'(dstM), 32'hF);
        check({tag, "_flags"}, {28'h0, mem_rd, busy, done, err}, 32'h0);
    endtask

    initial begin
        int len;
        reset_n = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        m_alufun = 4'h0;
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        #12;
        check_reset_values("reset");
        @(negedge clock);
        reset_n = 1'b1;

        // Load immediate then halt.
        mem[0] = 32'h10F00080;
        mem[1] = 32'h00000000;
        run_trace(-1);

        // ALU sequence, with a stray start pulse mid-run.
        mem[0] = 32'h20010000;
        mem[1] = 32'h21230000;
        mem[2] = 32'h22450000;
        mem[3] = 32'h23670000;
        mem[4] = 32'h00000000;
        run_trace(7);

        // Reset in the EXEC cycle of the third ALU op.
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (13) @(negedge clock);
        check("midrun_busy", 32'(busy), 32'h1);
        reset_n = 1'b0;
        #1;
        check_reset_values("midrun");
        @(negedge clock);
        reset_n = 1'b1;
        m_alufun = 4'h0;
        repeat (6) begin
            @(negedge clock);
            check("post_reset_dstE", 32'(dstE), 32'hF);
            check("post_reset_busy", 32'(busy), 32'h0);
        end

        // Illegal opcode at address 3, then a restart clears err.
        for (int i = 0; i < 3; i++) mem[i] = rand_legal();
        mem[3] = 32'h30000000;
        run_trace(-1);
        mem[0] = 32'h00000000;
        run_trace(-1);

        // stop raised during EXEC of instruction 0.
        mem[0] = 32'h21230000;
        mem[1] = 32'h00000000;
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        stop = 1'b1;
        @(negedge clock);
        check("stop_dstE", 32'(dstE), 32'h2);
        check("stop_alufun", 32'(alufun), 32'h1);
        @(negedge clock);
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_pc", 32'(pc_addr), 32'h1);
        check("stop_icount", 32'(icount), 32'h1);
        stop = 1'b0;
        m_alufun = 4'h1;

        // start and stop together in IDLE must not start.
        start = 1'b1;
        stop  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", 32'(busy), 32'h0);
        check("startstop_rd", 32'(mem_rd), 32'h0);
        @(negedge clock);
        check("startstop_pc", 32'(pc_addr), 32'h1);

        // Random programs ending in halt or an illegal opcode.
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(0, 10);
            for (int i = 0; i < len; i++) mem[i] = rand_legal();
            mem[len] = ($urandom_range(0, 1) == 0) ? {8'h00, 24'($urandom)} : rand_illegal();
            run_trace((len > 0) ? $urandom_range(0, 5 * len) : -1);
        end

        // pc wrap: retire all 512 words, stop on the last one.
        for (int i = 0; i < 512; i++) mem[i] = {6'b001000, 2'($urandom), 24'($urandom)};
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int c = 0; c < 4000 && pc_addr != 9'd511; c++) @(negedge clock);
        check("wrap_reach", 32'(pc_addr), 32'd511);
        stop = 1'b1;
        for (int c = 0; c < 10 && busy; c++) @(negedge clock);
        stop = 1'b0;
        check("wrap_busy", 32'(busy), 32'h0);
        check("wrap_pc", 32'(pc_addr), 32'h0);
        check("wrap_icount", 32'(icount), 32'd512);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
